enc: RTL and testbench

ENC -- requirements
Module: enc

---
 rtl/enc.sv | 201 ++++++++++++++++++++
 tb/tb_enc.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/enc.sv
// ENC: two-stage RV32I instruction encoder (fields in, 32-bit word out).
// S1 captures the request and its error status; S2 holds the assembled word.
// Optional feature: define ENC_RANGE_CHECK_EN to flag immediates that do not
// fit their format (word replaced by NOP); otherwise immediates are truncated.
module enc (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_cls,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_err,
  output logic [15:0] cnt_ok,
  output logic [15:0] cnt_err
);

  localparam logic [4:0] CLS_LOAD   = 5'b00000;
  localparam logic [4:0] CLS_OP_IMM = 5'b00100;
  localparam logic [4:0] CLS_AUIPC  = 5'b00101;
  localparam logic [4:0] CLS_STORE  = 5'b01000;
  localparam logic [4:0] CLS_OP     = 5'b01100;
  localparam logic [4:0] CLS_LUI    = 5'b01101;
  localparam logic [4:0] CLS_BRANCH = 5'b11000;
  localparam logic [4:0] CLS_JALR   = 5'b11001;
  localparam logic [4:0] CLS_JAL    = 5'b11011;
  localparam logic [4:0] CLS_SYSTEM = 5'b11100;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [2:0] {
    FMT_NONE, FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J
  } fmt_e;

  fmt_e        inFmt;
  logic        inImmBad;
  logic        s1Ready, s2Ready, accept, s2Load;
  logic        s1Valid_q, s1Valid_d, s2Valid_q, s2Valid_d;
  fmt_e        s1Fmt_q;
  logic        s1ImmBad_q;
  logic [4:0]  s1Cls_q, s1Rd_q, s1Rs1_q, s1Rs2_q;
  logic [2:0]  s1Funct3_q;
  logic [6:0]  s1Funct7_q;
  logic [31:0] s1Imm_q;
  logic [31:0] s2Instr_q, s2Instr_d;
  logic        s2Err_q, s2Err_d;
  logic [15:0] cntOk_q, cntErr_q;
  logic [6:0]  opcode;

  assign s2Ready  = !s2Valid_q || out_ready;
  assign s1Ready  = !s1Valid_q || s2Ready;
  assign in_ready = rst_n && s1Ready && !flush;
  assign accept   = in_valid && in_ready;
  assign s2Load   = s1Valid_q && s2Ready && !flush;

  // Map the opcode class onto an instruction format; unknown classes get FMT_NONE
  always_comb begin
    inFmt = FMT_NONE;
    case (in_cls)
      CLS_OP:                         inFmt = FMT_R;
      CLS_LOAD, CLS_JALR, CLS_SYSTEM: inFmt = FMT_I;
      CLS_OP_IMM:                     inFmt = (in_funct3[1:0] == 2'b01) ? FMT_SH : FMT_I;
      CLS_STORE:                      inFmt = FMT_S;
      CLS_BRANCH:                     inFmt = FMT_B;
      CLS_LUI, CLS_AUIPC:             inFmt = FMT_U;
      CLS_JAL:                        inFmt = FMT_J;
      default:                        inFmt = FMT_NONE;
    endcase
  end

`ifdef ENC_RANGE_CHECK_EN
  logic fitsI, fitsB, fitsJ, fitsU, fitsSh;
  assign fitsI  = (&in_imm[31:11]) || !(|in_imm[31:11]);
  assign fitsB  = ((&in_imm[31:12]) || !(|in_imm[31:12])) && !in_imm[0];
  assign fitsJ  = ((&in_imm[31:20]) || !(|in_imm[31:20])) && !in_imm[0];
  assign fitsU  = !(|in_imm[11:0]);
  assign fitsSh = !(|in_imm[31:5]);

  // Flag an immediate that cannot be represented in its format's field
  always_comb begin
    inImmBad = 1'b0;
    case (inFmt)
      FMT_I, FMT_S: inImmBad = !fitsI;
      FMT_SH:       inImmBad = !fitsSh;
      FMT_B:        inImmBad = !fitsB;
      FMT_J:        inImmBad = !fitsJ;
      FMT_U:        inImmBad = !fitsU;
      default:      inImmBad = 1'b0;
    endcase
  end
`else
  assign inImmBad = 1'b0;
`endif

  // Stage valids advance when the downstream slot frees; flush empties both
  always_comb begin
    s1Valid_d = s1Valid_q;
    s2Valid_d = s2Valid_q;
    if (flush) begin
      s1Valid_d = 1'b0;
      s2Valid_d = 1'b0;
    end else begin
      if (s1Ready) s1Valid_d = accept;
      if (s2Ready) s2Valid_d = s1Valid_q;
    end
  end

  assign opcode = {s1Cls_q, 2'b11};

  // Scatter S1 fields into the RV32I word; unknown class gives 0, bad imm gives NOP
  always_comb begin
    s2Instr_d = 32'h0;
    case (s1Fmt_q)
      FMT_R:  s2Instr_d = {s1Funct7_q, s1Rs2_q, s1Rs1_q, s1Funct3_q, s1Rd_q, opcode};
      FMT_I:  s2Instr_d = {s1Imm_q[11:0], s1Rs1_q, s1Funct3_q, s1Rd_q, opcode};
      FMT_SH: s2Instr_d = {s1Funct7_q, s1Imm_q[4:0], s1Rs1_q, s1Funct3_q, s1Rd_q, opcode};
      FMT_S:  s2Instr_d = {s1Imm_q[11:5], s1Rs2_q, s1Rs1_q, s1Funct3_q, s1Imm_q[4:0], opcode};
      FMT_B:  s2Instr_d = {s1Imm_q[12], s1Imm_q[10:5], s1Rs2_q, s1Rs1_q, s1Funct3_q,
                           s1Imm_q[4:1], s1Imm_q[11], opcode};
      FMT_U:  s2Instr_d = {s1Imm_q[31:12], s1Rd_q, opcode};
      FMT_J:  s2Instr_d = {s1Imm_q[20], s1Imm_q[10:1], s1Imm_q[11], s1Imm_q[19:12],
                           s1Rd_q, opcode};
      default: s2Instr_d = 32'h0;
    endcase
    s2Err_d = (s1Fmt_q == FMT_NONE) || s1ImmBad_q;
    if (s1Fmt_q != FMT_NONE && s1ImmBad_q) s2Instr_d = NOP_WORD;
  end

  // Stage 1: capture the accepted request and its error status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1Valid_q  <= 1'b0;
      s1Fmt_q    <= FMT_NONE;
      s1ImmBad_q <= 1'b0;
      s1Cls_q    <= 5'h0;
      s1Rd_q     <= 5'h0;
      s1Rs1_q    <= 5'h0;
      s1Rs2_q    <= 5'h0;
      s1Funct3_q <= 3'h0;
      s1Funct7_q <= 7'h0;
      s1Imm_q    <= 32'h0;
    end else begin
      s1Valid_q <= s1Valid_d;
      if (accept) begin
        s1Fmt_q    <= inFmt;
        s1ImmBad_q <= inImmBad;
        s1Cls_q    <= in_cls;
        s1Rd_q     <= in_rd;
        s1Rs1_q    <= in_rs1;
        s1Rs2_q    <= in_rs2;
        s1Funct3_q <= in_funct3;
        s1Funct7_q <= in_funct7;
        s1Imm_q    <= in_imm;
      end
    end
  end

  // Stage 2: hold the assembled word until the consumer takes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2Valid_q <= 1'b0;
      s2Instr_q <= 32'h0;
      s2Err_q   <= 1'b0;
    end else begin
      s2Valid_q <= s2Valid_d;
      if (s2Load) begin
        s2Instr_q <= s2Instr_d;
        s2Err_q   <= s2Err_d;
      end
    end
  end

  // Count delivered words by error status, saturating at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cntOk_q  <= 16'h0;
      cntErr_q <= 16'h0;
    end else if (s2Valid_q && out_ready) begin
      if (s2Err_q) begin
        if (cntErr_q != 16'hFFFF) cntErr_q <= cntErr_q + 16'd1;
      end else begin
        if (cntOk_q != 16'hFFFF) cntOk_q <= cntOk_q + 16'd1;
      end
    end
  end

  assign out_valid = s2Valid_q;
  assign out_instr = s2Instr_q;
  assign out_err   = s2Err_q;
  assign cnt_ok    = cntOk_q;
  assign cnt_err   = cntErr_q;

endmodule

// File: tb/tb_enc.sv
// Directed self-checking bench for the enc RV32I encoder.
// Expectations for the out-of-range immediate case follow ENC_RANGE_CHECK_EN.
module tb_enc;

  logic        clk, rst_n, flush, in_valid, in_ready;
  logic [4:0]  in_cls, in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid, out_ready, out_err;
  logic [31:0] out_instr;
  logic [15:0] cnt_ok, cnt_err;

  int checks = 0;
  int errors = 0;
  int expOk  = 0;
  int expErr = 0;

  typedef struct packed {
    logic [4:0]  cls;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] instr;
    logic        err;
  } vec_t;

  vec_t vecs[12];

  enc dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_cls(in_cls), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_err(out_err),
    .cnt_ok(cnt_ok), .cnt_err(cnt_err)
  );

  // Free-running clock, 10 time units per period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mkVec(input logic [4:0] cls, input logic [4:0] rd,
                                 input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [2:0] f3, input logic [6:0] f7,
                                 input logic [31:0] imm, input logic [31:0] instr,
                                 input logic err);
    vec_t v;
    v.cls = cls; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.f3 = f3; v.f7 = f7; v.imm = imm; v.instr = instr; v.err = err;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    in_cls = v.cls; in_rd = v.rd; in_rs1 = v.rs1; in_rs2 = v.rs2;
    in_funct3 = v.f3; in_funct7 = v.f7; in_imm = v.imm;
    in_valid = 1'b1;
    #1;
  endtask

  task automatic doReset();
    in_valid = 1'b0;
    flush = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    expOk = 0;
    expErr = 0;
  endtask

  // One isolated word: accepted, invisible after 1 edge, present after 2, gone after handshake
  task automatic test_single(input vec_t v, input string tag);
    out_ready = 1'b1;
    applyStimulus(v);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL %s in_ready: got %b want 1", tag, in_ready); end
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL %s early_valid: got %b want 0", tag, out_valid); end
    step();
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL %s out_valid: got %b want 1", tag, out_valid); end
    checks++;
    if (out_instr !== v.instr) begin errors++; $display("[TB] FAIL %s out_instr: got %h want %h", tag, out_instr, v.instr); end
    checks++;
    if (out_err !== v.err) begin errors++; $display("[TB] FAIL %s out_err: got %b want %b", tag, out_err, v.err); end
    if (v.err) expErr++; else expOk++;
    step();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL %s drained: got %b want 0", tag, out_valid); end
    checks++;
    if (cnt_ok !== 16'(expOk)) begin errors++; $display("[TB] FAIL %s cnt_ok: got %0d want %0d", tag, cnt_ok, expOk); end
    checks++;
    if (cnt_err !== 16'(expErr)) begin errors++; $display("[TB] FAIL %s cnt_err: got %0d want %0d", tag, cnt_err, expErr); end
  endtask

  task automatic test_reset();
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_cls = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_funct3 = '0; in_funct7 = '0; in_imm = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset out_valid: got %b want 0", out_valid); end
    checks++;
    if (out_instr !== 32'h0) begin errors++; $display("[TB] FAIL reset out_instr: got %h want 0", out_instr); end
    checks++;
    if (out_err !== 1'b0) begin errors++; $display("[TB] FAIL reset out_err: got %b want 0", out_err); end
    checks++;
    if (cnt_ok !== 16'h0 || cnt_err !== 16'h0) begin errors++; $display("[TB] FAIL reset counters: got %0d/%0d want 0/0", cnt_ok, cnt_err); end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset in_ready: got %b want 0", in_ready); end
    step();
    step();
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset release in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_basic();
    vec_t v;
    v = mkVec(5'b00100, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h0050_0093, 1'b0);
    test_single(v, "addi_basic");
  endtask

  task automatic test_encoding();
    for (int i = 0; i < 12; i++) begin
      test_single(vecs[i], $sformatf("enc%0d", i));
    end
  endtask

  // Four words streamed on consecutive cycles must emerge one per cycle, 2 cycles later
  task automatic test_back_to_back();
    int idx[4] = '{3, 4, 5, 6};
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c < 4) begin
        applyStimulus(vecs[idx[c]]);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b in_ready c%0d: got %b want 1", c, in_ready); end
      end else begin
        in_valid = 1'b0;
        #1;
      end
      if (c >= 2) begin
        checks++;
        if (out_valid !== 1'b1 || out_instr !== vecs[idx[c-2]].instr) begin
          errors++;
          $display("[TB] FAIL b2b word c%0d: got v=%b %h want v=1 %h", c, out_valid, out_instr, vecs[idx[c-2]].instr);
        end
        expOk++;
      end
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b drained: got %b want 0", out_valid); end
    checks++;
    if (cnt_ok !== 16'(expOk)) begin errors++; $display("[TB] FAIL b2b cnt_ok: got %0d want %0d", cnt_ok, expOk); end
  endtask

  task automatic test_range();
    vec_t v;
    doReset();
`ifdef ENC_RANGE_CHECK_EN
    v = mkVec(5'b00100, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800, 32'h0000_0013, 1'b1);
`else
    v = mkVec(5'b00100, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800, 32'h8000_0093, 1'b0);
`endif
    test_single(v, "addi_imm800");
`ifdef ENC_RANGE_CHECK_EN
    checks++;
    if (cnt_err !== 16'd1 || cnt_ok !== 16'd0) begin errors++; $display("[TB] FAIL range counters: got ok=%0d err=%0d want 0/1", cnt_ok, cnt_err); end
    v = mkVec(5'b00100, 5'd1, 5'd1, 5'd0, 3'b001, 7'd0, 32'h20, 32'h0000_0013, 1'b1);
`else
    checks++;
    if (cnt_err !== 16'd0 || cnt_ok !== 16'd1) begin errors++; $display("[TB] FAIL range counters: got ok=%0d err=%0d want 1/0", cnt_ok, cnt_err); end
    v = mkVec(5'b00100, 5'd1, 5'd1, 5'd0, 3'b001, 7'd0, 32'h20, 32'h0000_9093, 1'b0);
`endif
    test_single(v, "slli_imm32");
  endtask

  // Consumer stalls: two entries fill the pipe, then three words drain in order
  task automatic test_stall();
    vec_t s[3];
    doReset();
    s[0] = mkVec(5'b00100, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 32'h0010_0093, 1'b0);
    s[1] = mkVec(5'b00100, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2, 32'h0020_0093, 1'b0);
    s[2] = mkVec(5'b00100, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 32'h0030_0093, 1'b0);
    out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      applyStimulus(s[c]);
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL stall accept%0d in_ready: got %b want 1", c, in_ready); end
      step();
    end
    applyStimulus(s[2]);
    for (int c = 0; c < 2; c++) begin
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL stall in_ready_drop c%0d: got %b want 0", c, in_ready); end
      checks++;
      if (out_valid !== 1'b1 || out_instr !== s[0].instr) begin errors++; $display("[TB] FAIL stall hold c%0d: got v=%b %h want v=1 %h", c, out_valid, out_instr, s[0].instr); end
      step();
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL stall release in_ready: got %b want 1", in_ready); end
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (out_valid !== 1'b1 || out_instr !== s[c].instr) begin errors++; $display("[TB] FAIL stall order%0d: got v=%b %h want v=1 %h", c, out_valid, out_instr, s[c].instr); end
      step();
      in_valid = 1'b0;
    end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL stall drained: got %b want 0", out_valid); end
    checks++;
    if (cnt_ok !== 16'd3 || cnt_err !== 16'd0) begin errors++; $display("[TB] FAIL stall counters: got ok=%0d err=%0d want 3/0", cnt_ok, cnt_err); end
    expOk = 3;
  endtask

  task automatic test_flush();
    vec_t f;
    f = mkVec(5'b00100, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd9, 32'h0090_0113, 1'b0);
    out_ready = 1'b0;
    applyStimulus(f); step();
    applyStimulus(f); step();
    flush = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL flush in_ready: got %b want 0", in_ready); end
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush stale c%0d: got %b %h want 0", c, out_valid, out_instr); end
      step();
    end
    checks++;
    if (cnt_ok !== 16'(expOk) || cnt_err !== 16'(expErr)) begin errors++; $display("[TB] FAIL flush counters: got %0d/%0d want %0d/%0d", cnt_ok, cnt_err, expOk, expErr); end
    test_single(mkVec(5'b00100, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7, 32'h0070_0093, 1'b0), "post_flush");
  endtask

  task automatic test_reset_midflight();
    vec_t f;
    f = mkVec(5'b01101, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'hABCDE000, 32'hABCD_E1B7, 1'b0);
    out_ready = 1'b0;
    applyStimulus(f); step();
    applyStimulus(f); step();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_instr !== 32'h0 || out_err !== 1'b0) begin errors++; $display("[TB] FAIL midreset outputs: got v=%b %h e=%b want 0", out_valid, out_instr, out_err); end
    checks++;
    if (cnt_ok !== 16'h0 || in_ready !== 1'b0) begin errors++; $display("[TB] FAIL midreset cnt/in_ready: got %0d/%b want 0/0", cnt_ok, in_ready); end
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    expOk = 0;
    expErr = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL midreset stale c%0d: got %b %h want 0", c, out_valid, out_instr); end
      step();
    end
    test_single(f, "post_reset");
  endtask

  // Hand-encoded reference vectors for the isolated-word table
  task automatic loadVectors();
    vecs[0]  = mkVec(5'b11000, 5'd0,  5'd0, 5'd0, 3'd0, 7'd0,  32'hFFFF_FFFC, 32'hFE00_0EE3, 1'b0);
    vecs[1]  = mkVec(5'b01101, 5'd5,  5'd0, 5'd0, 3'd0, 7'd0,  32'h1234_5000, 32'h1234_52B7, 1'b0);
    vecs[2]  = mkVec(5'b11011, 5'd1,  5'd0, 5'd0, 3'd0, 7'd0,  32'h0000_0800, 32'h0010_00EF, 1'b0);
    vecs[3]  = mkVec(5'b01100, 5'd3,  5'd1, 5'd2, 3'd0, 7'h20, 32'hFFFF_FFFF, 32'h4020_81B3, 1'b0);
    vecs[4]  = mkVec(5'b01000, 5'd31, 5'd1, 5'd2, 3'd2, 7'd0,  32'h0000_0008, 32'h0020_A423, 1'b0);
    vecs[5]  = mkVec(5'b00100, 5'd5,  5'd6, 5'd0, 3'd5, 7'h20, 32'h0000_0003, 32'h4033_5293, 1'b0);
    vecs[6]  = mkVec(5'b11001, 5'd0,  5'd1, 5'd7, 3'd0, 7'd0,  32'h0000_0000, 32'h0000_8067, 1'b0);
    vecs[7]  = mkVec(5'b00101, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0,  32'hFFFF_F000, 32'hFFFF_F517, 1'b0);
    vecs[8]  = mkVec(5'b00011, 5'd1,  5'd1, 5'd1, 3'd0, 7'd0,  32'h0000_0000, 32'h0000_0000, 1'b1);
    vecs[9]  = mkVec(5'b11111, 5'd0,  5'd0, 5'd0, 3'd0, 7'd0,  32'h0000_0000, 32'h0000_0000, 1'b1);
    vecs[10] = mkVec(5'b00000, 5'd4,  5'd2, 5'd0, 3'd2, 7'd0,  32'hFFFF_FFFC, 32'hFFC1_2203, 1'b0);
    vecs[11] = mkVec(5'b11100, 5'd0,  5'd0, 5'd0, 3'd0, 7'd0,  32'h0000_0000, 32'h0000_0073, 1'b0);
  endtask

  // Run every scenario in order, then report
  initial begin
    loadVectors();
    test_reset();
    test_basic();
    test_encoding();
    test_back_to_back();
    test_range();
    test_stall();
    test_flush();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
